mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-to-one arbiter that shares a single-ported unified memory between the core's instruction-fetch port and its load/store data port. It sits between the core and the memory. It runs a req/gnt/rvalid handshake on every port, with at most one transaction outstanding at a time. Data accesses have priority, and a streak limit guarantees fetch progress. An instruction flush discards a pending fetch response.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, read/write data width
- BE_WIDTH, 4, byte-enable width
- STREAK, 4, max consecutive data grants while a fetch waits (>=1)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req_i / i_addr_i  in  1 / ADDR_WIDTH  fetch request and address; held stable until i_gnt_o
- i_gnt_o, i_rvalid_o  out  1  fetch grant, fetch response valid
- i_rdata_o  out  DATA_WIDTH  fetch read data
- flush_i  in  1  discard any pending or outstanding fetch
- d_req_i, d_wr_i  in  1  data request and write flag; held with address, wdata and be until d_gnt_o
- d_addr_i  in  ADDR_WIDTH  data address
- d_wdata_i  in  DATA_WIDTH  write data
- d_be_i  in  BE_WIDTH  byte enables
- d_gnt_o, d_rvalid_o  out  1  data grant, data response valid (writes also get rvalid)
- d_rdata_o  out  DATA_WIDTH  load data
- m_req_o, m_wr_o  out  1  memory request and write flag
- m_addr_o  out  ADDR_WIDTH  memory address
- m_wdata_o  out  DATA_WIDTH  memory write data
- m_be_o  out  BE_WIDTH  memory byte enables
- m_gnt_i, m_rvalid_i  in  1  memory grant and response valid (rvalid no earlier than the cycle after gnt)
- m_rdata_i  in  DATA_WIDTH  memory read data

## Operation
- **FSM states.** IDLE, REQ, WAIT. Registered signals: owner (0=instr, 1=data), drop flag, and a streak counter of $clog2(STREAK+1) bits.
- **Arbitration.** Evaluated in IDLE, and in WAIT on the cycle m_rvalid_i arrives.
  - Winner is data if d_req_i, unless i_req_i is also set and streak==STREAK, in which case instr wins.
  - Otherwise the winner is instr if i_req_i and not flush_i.
  - The winner is registered as owner, and the FSM moves to REQ on the next cycle.
  - If there is no winner, the FSM goes to IDLE.
- **REQ.**
  - m_req_o=1. m_addr_o, m_wr_o, m_wdata_o and m_be_o are muxed combinationally from the owner's inputs; instr forces m_wr_o=0 and m_be_o all-ones.
  - The owner's gnt_o equals m_gnt_i. On m_gnt_i the FSM goes to WAIT.
  - If owner is instr and flush_i=1 without m_gnt_i, the request is abandoned: m_req_o drops, the FSM returns to IDLE, and i_gnt_o stays 0.
  - If flush_i=1 together with m_gnt_i on a fetch, the grant is taken and drop is set.
- **WAIT.**
  - m_req_o=0. On m_rvalid_i, the owner's rvalid_o=1 and its rdata_o=m_rdata_i in the same cycle.
  - If owner is instr and either drop is set or flush_i is high that cycle, i_rvalid_o is suppressed.
  - flush_i in WAIT with instr owner sets drop. drop clears on leaving WAIT.
- **Streak counter.**
  - Increments, saturating at STREAK, on each data m_gnt_i while i_req_i=1.
  - Clears on an instr grant, or on any cycle with i_req_i=0.
- **Stray inputs.** m_rvalid_i in IDLE or REQ is ignored. Rdata outputs equal m_rdata_i unconditionally; only the rvalid outputs qualify them.
- **Reset values.** All outputs 0 except the data/address muxes, which follow the now-owner=instr inputs. Reset puts the FSM in IDLE with owner=0, drop=0 and streak=0. A reset mid-transaction abandons the transaction, and any later m_rvalid_i is ignored.

## Timing
- The arbitration decision is registered, so m_req_o rises 1 cycle after a requester's req in IDLE.
- Minimum fetch latency: req at cycle t; m_req_o and gnt at t+1 (if m_gnt_i is immediate); rvalid at t+2.
- Back-to-back: if a request is pending when m_rvalid_i arrives, the next m_req_o is asserted on the following cycle, with no IDLE cycle.
- All grant and response outputs are combinational from m_gnt_i / m_rvalid_i gated by registered state. No registered data path.
- Arbitration sees the inputs of the cycle it evaluates. Simultaneous i_req_i and d_req_i with streak<STREAK give data the win.

## Test plan
- **Single fetch.** i_req_i=1, i_addr_i=0x100 at t0; memory grants immediately and returns 0xDEADBEEF at t2 → m_req_o=1, m_addr_o=0x100, m_wr_o=0 at t1; i_gnt_o at t1; i_rvalid_o=1 with i_rdata_o=0xDEADBEEF at t2.
- **Store then fetch.** d_req_i=1, d_wr_i=1, addr 0x2004, wdata 0x55, be 0x1, with i_req_i held → data is granted first with m_be_o=0x1; d_rvalid_o on its response; fetch m_req_o on the next cycle.
- **Starvation guard, STREAK=4.** d_req_i and i_req_i held continuously → grant sequence D,D,D,D,I,D,D,D,D,I.
- **Flush in WAIT.** Fetch granted at t1; flush_i at t2; m_rvalid_i at t3 → i_rvalid_o stays 0, FSM returns to IDLE, and the next fetch proceeds normally.
- **Slow grant with flush.** Fetch in REQ with m_gnt_i=0 for 3 cycles; flush_i on the 2nd cycle → m_req_o drops the next cycle and no i_gnt_o is issued.
- **Reset mid-WAIT.** rst_n low for 1 cycle during a data WAIT; stray m_rvalid_i afterward → all outputs 0, d_rvalid_o never pulses, FSM in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-to-one arbiter sharing a single-ported memory between the instruction-fetch
// port and the load/store data port. It keeps one transaction in flight at a time.
// Data wins by default. A streak counter hands the slot to a waiting fetch after
// STREAK consecutive data grants. flush_i abandons or silences the pending fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4,
    parameter int unsigned STREAK     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Instruction-fetch port
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_gnt_o,
    output logic                  i_rvalid_o,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    input  logic                  flush_i,

    // Load/store data port
    input  logic                  d_req_i,
    input  logic                  d_wr_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic [BE_WIDTH-1:0]   d_be_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,

    // Memory port
    output logic                  m_req_o,
    output logic                  m_wr_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    output logic [BE_WIDTH-1:0]   m_be_o,
    input  logic                  m_gnt_i,
    input  logic                  m_rvalid_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i
);

    localparam int unsigned StreakW = $clog2(STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STREAK);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = instr, 1 = data
    logic                drop_q, drop_d;     // outstanding fetch response to be discarded
    logic [StreakW-1:0]  streak_q, streak_d;

    logic in_req;
    logic in_wait;
    logic arb_en;
    logic force_instr;
    logic win_data;
    logic win_instr;
    logic rsp;

    assign in_req  = (state_q == StReq);
    assign in_wait = (state_q == StWait);
    assign rsp     = in_wait && m_rvalid_i;

    // Winner selection on the current cycle's request inputs
    always_comb begin
        force_instr = i_req_i && !flush_i && (streak_q == StreakMax);
        win_data    = d_req_i && !force_instr;
        win_instr   = !win_data && i_req_i && !flush_i;
    end

    // Next-state for FSM, owner and drop flag
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        arb_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                arb_en = 1'b1;
            end
            StReq: begin
                if (m_gnt_i) begin
                    state_d = StWait;
                    // Grant taken but the response belongs to a flushed stream
                    if (!owner_q && flush_i) begin
                        drop_d = 1'b1;
                    end
                end else if (!owner_q && flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (!owner_q && flush_i) begin
                    drop_d = 1'b1;
                end
                if (m_rvalid_i) begin
                    arb_en = 1'b1;
                    drop_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arb_en) begin
            if (win_data) begin
                state_d = StReq;
                owner_d = 1'b1;
            end else if (win_instr) begin
                state_d = StReq;
                owner_d = 1'b0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Streak of data grants taken while a fetch is waiting
    always_comb begin
        streak_d = streak_q;
        if (i_gnt_o || !i_req_i) begin
            streak_d = '0;
        end else if (d_gnt_o && (streak_q != StreakMax)) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    // Grant/response qualification and memory-side muxing
    always_comb begin
        m_req_o    = in_req;
        i_gnt_o    = in_req && !owner_q && m_gnt_i;
        d_gnt_o    = in_req && owner_q && m_gnt_i;
        i_rvalid_o = rsp && !owner_q && !drop_q && !flush_i;
        d_rvalid_o = rsp && owner_q;
        i_rdata_o  = m_rdata_i;
        d_rdata_o  = m_rdata_i;

        if (owner_q) begin
            m_addr_o  = d_addr_i;
            m_wr_o    = d_wr_i;
            m_wdata_o = d_wdata_i;
            m_be_o    = d_be_i;
        end else begin
            m_addr_o  = i_addr_i;
            m_wr_o    = 1'b0;
            m_wdata_o = '0;
            m_be_o    = '1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            drop_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            streak_q <= streak_d;
        end
    end

endmodule
